// File: rtl/serializer_8bit.sv
// Serializer for one 8-bit word, framed as start(0), data MSB first, optional even parity, stop(1).
// Define SERIALIZER_PARITY_EN to insert the parity bit between data bit 0 and the stop bit.
module serializer_8bit #(
    parameter int BIT_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst_bar,
    input  logic [7:0] data_in,
    input  logic       ld_bar,
    output logic       ser_out,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] LAST_TICK = 8'(BIT_TICKS - 1);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t     state;
    logic [7:0] tick;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       last_tick;

    assign last_tick = (tick == LAST_TICK);

    // The captured word is never shifted, so it stays stable for the whole frame;
    // bit_cnt selects the data bit currently on the line.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state      <= IDLE;
            tick       <= 8'd0;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'd0;
            ser_out    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    ser_out <= 1'b1;
                    tick    <= 8'd0;
                    if (!ld_bar) begin
                        shift_reg <= data_in;
                        state     <= START;
                        busy      <= 1'b1;
                        ser_out   <= 1'b0;
                    end
                end
                START: begin
                    if (last_tick) begin
                        tick    <= 8'd0;
                        state   <= DATA;
                        bit_cnt <= 3'd7;
                        ser_out <= shift_reg[7];
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        tick <= 8'd0;
                        if (bit_cnt == 3'd0) begin
`ifdef SERIALIZER_PARITY_EN
                            state   <= PARITY;
                            ser_out <= ^shift_reg;
`else
                            state   <= STOP;
                            ser_out <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            ser_out <= shift_reg[bit_cnt - 3'd1];
                        end
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                PARITY: begin
                    if (last_tick) begin
                        tick    <= 8'd0;
                        state   <= STOP;
                        ser_out <= 1'b1;
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
`endif
                STOP: begin
                    // Dropping busy here makes the frame_done cycle double as the idle-high gap.
                    if (last_tick) begin
                        tick       <= 8'd0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        tick <= tick + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ser_out <= 1'b1;
                    tick    <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_8bit.sv
// Self-checking bench for serializer_8bit: one instance at BIT_TICKS=1 (a) and one at BIT_TICKS=4 (b),
// compared cycle by cycle against a frame model built from the bit-ordering rules.
module tb_serializer_8bit;

`ifdef SERIALIZER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_bar;
    logic [7:0] data_a, data_b;
    logic       ld_a, ld_b;
    logic       ser_a, busy_a, fd_a;
    logic       ser_b, busy_b, fd_b;

    int vectors;
    int miscompares;

    logic cap_ser  [0:127];
    logic cap_busy [0:127];
    logic cap_fd   [0:127];

    serializer_8bit #(.BIT_TICKS(1)) dut_a (
        .clk(clk), .rst_bar(rst_bar), .data_in(data_a), .ld_bar(ld_a),
        .ser_out(ser_a), .busy(busy_a), .frame_done(fd_a)
    );

    serializer_8bit #(.BIT_TICKS(4)) dut_b (
        .clk(clk), .rst_bar(rst_bar), .data_in(data_b), .ld_bar(ld_b),
        .ser_out(ser_b), .busy(busy_b), .frame_done(fd_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int frame_bits();
        return PARITY_EN ? 11 : 10;
    endfunction

    // Bit k of the frame: 0 = start, 1..8 = data MSB first, then parity (if enabled), then stop.
    function automatic logic model_bit(input logic [7:0] d, input int k);
        int ones;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[8 - k];
        if (PARITY_EN && k == 9) begin
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(d[i]);
            return (ones % 2) == 1;
        end
        return 1'b1;
    endfunction

    // Expected outputs i cycles after the first start-bit cycle of a frame carrying d.
    task automatic exp_at(input logic [7:0] d, input int bt, input int i,
                          output logic s, output logic b, output logic f);
        int len;
        len = frame_bits() * bt;
        if (i < len) begin
            s = model_bit(d, i / bt); b = 1'b1; f = 1'b0;
        end else if (i == len) begin
            s = 1'b1; b = 1'b0; f = 1'b1;
        end else begin
            s = 1'b1; b = 1'b0; f = 1'b0;
        end
    endtask

    // Leaves the bench on the negedge of the first start-bit cycle.
    task automatic start_load(input int which, input logic [7:0] d);
        @(negedge clk);
        if (which == 0) begin ld_a = 1'b0; data_a = d; end
        else            begin ld_b = 1'b0; data_b = d; end
        @(negedge clk);
        if (which == 0) ld_a = 1'b1;
        else            ld_b = 1'b1;
    endtask

    task automatic capture(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) begin
                cap_ser[i] = ser_a; cap_busy[i] = busy_a; cap_fd[i] = fd_a;
            end else begin
                cap_ser[i] = ser_b; cap_busy[i] = busy_b; cap_fd[i] = fd_b;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_bar = 1'b1;
        ld_a = 1'b1; ld_b = 1'b1; data_a = 8'h00; data_b = 8'h00;
        #2 rst_bar = 1'b0;
        #1;
        vectors++;
        if ({ser_a, busy_a, fd_a, ser_b, busy_b, fd_b} !== 6'b100100) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b expected 100100",
                     {ser_a, busy_a, fd_a, ser_b, busy_b, fd_b});
        end
        @(negedge clk);
        ld_a = 1'b0; data_a = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({ser_a, busy_a, fd_a} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL load_in_reset cycle %0d: got %b expected 100", i, {ser_a, busy_a, fd_a});
            end
        end
        ld_a = 1'b1;
        rst_bar = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ser_a, busy_a, fd_a} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL after_reset: got %b expected 100", {ser_a, busy_a, fd_a});
        end
    endtask

    task automatic test_frame(input string name, input int which, input logic [7:0] d);
        int bt;
        int n;
        logic s, b, f;
        bt = (which == 0) ? 1 : 4;
        n  = frame_bits() * bt + 2;
        start_load(which, d);
        capture(which, n);
        for (int i = 0; i < n; i++) begin
            exp_at(d, bt, i, s, b, f);
            vectors++;
            if ({cap_ser[i], cap_busy[i], cap_fd[i]} !== {s, b, f}) begin
                miscompares++;
                $display("[TB] FAIL %s data=%h cycle %0d: ser/busy/done=%b expected %b",
                         name, d, i, {cap_ser[i], cap_busy[i], cap_fd[i]}, {s, b, f});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom);
            test_frame("random", r % 2, d);
        end
    endtask

    task automatic test_ignore_load();
        logic [7:0] d;
        int n;
        logic s, b, f;
        d = 8'h0F;
        n = frame_bits() + 3;
        start_load(0, d);
        for (int i = 0; i < n; i++) begin
            if (i == 3) begin ld_a = 1'b0; data_a = 8'hFF; end
            if (i == 7) ld_a = 1'b1;
            exp_at(d, 1, i, s, b, f);
            vectors++;
            if ({ser_a, busy_a, fd_a} !== {s, b, f}) begin
                miscompares++;
                $display("[TB] FAIL ignore_load cycle %0d: ser/busy/done=%b expected %b",
                         i, {ser_a, busy_a, fd_a}, {s, b, f});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'($urandom) & 8'hF7;
        start_load(0, d);
        // Cycle 5 carries data bit 3 (start, then bits 7,6,5,4).
        for (int i = 0; i < 5; i++) @(negedge clk);
        vectors++;
        if ({ser_a, busy_a} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL before_abort: ser/busy=%b expected 01", {ser_a, busy_a});
        end
        rst_bar = 1'b0;
        #1;
        vectors++;
        if ({ser_a, busy_a, fd_a} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL abort_immediate: ser/busy/done=%b expected 100", {ser_a, busy_a, fd_a});
        end
        @(negedge clk);
        rst_bar = 1'b1;
        for (int i = 0; i < frame_bits() + 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({ser_a, busy_a, fd_a} !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL abort_quiet cycle %0d: ser/busy/done=%b expected 100",
                         i, {ser_a, busy_a, fd_a});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2;
        int len;
        logic s, b, f;
        d1 = 8'h81; d2 = 8'h7E;
        len = frame_bits();
        @(negedge clk);
        ld_a = 1'b0; data_a = d1;
        @(negedge clk);
        data_a = d2;
        for (int i = 0; i < 2 * len + 3; i++) begin
            if (i == len + 1) ld_a = 1'b1;
            if (i <= len) exp_at(d1, 1, i, s, b, f);
            else          exp_at(d2, 1, i - len - 1, s, b, f);
            vectors++;
            if ({ser_a, busy_a, fd_a} !== {s, b, f}) begin
                miscompares++;
                $display("[TB] FAIL back_to_back cycle %0d: ser/busy/done=%b expected %b",
                         i, {ser_a, busy_a, fd_a}, {s, b, f});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_frame("basic_aa", 0, 8'hAA);
        test_frame("parity_cc", 0, 8'hCC);
        test_frame("parity_f1", 0, 8'hF1);
        test_frame("slow_55", 1, 8'h55);
        test_random();
        test_ignore_load();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
